pipe_skid_reg: RTL

PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

---
 rtl/pipe_skid_reg.sv | 128 ++++++++++++
 1 files changed

// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: two-entry register slice (main + skid) that cuts every
// combinational path between the upstream and downstream handshakes.
//
// Handshake: a transfer happens on a rising clk edge when valid and ready
// are both 1 on that side; valid never depends on ready, and every output
// (s_ready, m_valid, m_data) comes straight from a flop.
//
// Optional feature: define PIPE_SKID_REG_STATS_EN to add the xfer_cnt
// (wrapping) and stall_cnt (saturating) statistics outputs.
module pipe_skid_reg #(
  parameter int unsigned      WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  input  logic [WIDTH-1:0] s_data,
  output logic             s_ready,
  output logic             m_valid,
  output logic [WIDTH-1:0] m_data,
  input  logic             m_ready,
`ifdef PIPE_SKID_REG_STATS_EN
  output logic [15:0]      xfer_cnt,
  output logic [15:0]      stall_cnt,
`endif
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             s_ready_q;
  logic             m_valid_q;
  logic             s_xfer;

  // Gate upstream acceptance with the registered ready so the single
  // not-ready cycle straight after reset release never takes data.
  assign s_xfer = s_valid & s_ready_q;

  // Next-state and next-register values for the slice.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (s_xfer) begin
          state_d = ONE;
          main_d  = s_data;
        end
      end
      ONE: begin
        if (s_xfer && m_ready) begin
          main_d = s_data;
        end else if (s_xfer) begin
          state_d = TWO;
          skid_d  = s_data;
        end else if (m_ready) begin
          state_d = EMPTY;
          main_d  = RESET_VALUE;
        end
      end
      TWO: begin
        // s_ready is 0 here, so upstream is ignored.
        if (m_ready) begin
          state_d = ONE;
          main_d  = skid_q;
        end
      end
      default: begin
        state_d = EMPTY;
        main_d  = RESET_VALUE;
      end
    endcase
  end

  // State and data registers; handshake outputs registered from next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= EMPTY;
      main_q    <= RESET_VALUE;
      skid_q    <= RESET_VALUE;
      s_ready_q <= 1'b0;
      m_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      main_q    <= main_d;
      skid_q    <= skid_d;
      s_ready_q <= (state_d != TWO);
      m_valid_q <= (state_d != EMPTY);
    end
  end

  assign s_ready   = s_ready_q;
  assign m_valid   = m_valid_q;
  assign m_data    = main_q;
  assign state_dbg = state_q;

`ifdef PIPE_SKID_REG_STATS_EN
  logic [15:0] xfer_q;
  logic [15:0] stall_q;

  // Downstream transfer counter (wraps) and stall counter (saturates).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xfer_q  <= 16'h0000;
      stall_q <= 16'h0000;
    end else begin
      if (m_valid_q && m_ready) begin
        xfer_q <= xfer_q + 16'h0001;
      end
      if (m_valid_q && !m_ready && (stall_q != 16'hFFFF)) begin
        stall_q <= stall_q + 16'h0001;
      end
    end
  end

  assign xfer_cnt  = xfer_q;
  assign stall_cnt = stall_q;
`endif

endmodule
